// File: rtl/regfile_mp_if.sv
// Register-file bus: two read ports, two write ports, a pending-bit mark port and the clear-busy flag.
// The master drives selects, write data and marks; the slave returns read data, pending bits and init_busy.
interface regfile_mp_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
);
   logic             init_busy;
   logic [AW-1:0]    rsel0;
   logic [AW-1:0]    rsel1;
   logic [WIDTH-1:0] rdata0;
   logic [WIDTH-1:0] rdata1;
   logic             we0;
   logic             we1;
   logic [AW-1:0]    wsel0;
   logic [AW-1:0]    wsel1;
   logic [WIDTH-1:0] wdata0;
   logic [WIDTH-1:0] wdata1;
   logic             mark_en;
   logic [AW-1:0]    mark_sel;
   logic             pend0;
   logic             pend1;

   modport master (
      input  init_busy, rdata0, rdata1, pend0, pend1,
      output rsel0, rsel1, we0, we1, wsel0, wsel1, wdata0, wdata1, mark_en, mark_sel
   );

   modport slave (
      output init_busy, rdata0, rdata1, pend0, pend1,
      input  rsel0, rsel1, we0, we1, wsel0, wsel1, wdata0, wdata1, mark_en, mark_sel
   );
endinterface

// File: rtl/regfile_mp.sv
// 2R/2W register file with per-entry pending bits and a self-clear sequence after reset.
// Reads are combinational (optional same-cycle write bypass), writes land on the edge; no backpressure, only init_busy.
module regfile_mp #(
   parameter int WIDTH    = 32,
   parameter int NREGS    = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic         clk,
   input  logic         reset,
   regfile_mp_if.slave  bus
);
   typedef enum logic {CLEAR, IDLE} state_t;

   localparam logic [AW:0]   NREGS_X = (AW+1)'(NREGS);
   localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

   state_t           state;
   state_t           state_nxt;
   logic [AW-1:0]    cnt;
   logic [AW-1:0]    cnt_nxt;
   logic             busy;
   logic             idle;
   logic [WIDTH-1:0] mem [NREGS];
   logic [NREGS-1:0] pend;
   logic             wv0;
   logic             wv1;
   logic             mv;

   // An entry is addressable when it exists and is not the hardwired zero entry.
   function automatic logic sel_ok(input logic [AW-1:0] sel);
      return ({1'b0, sel} < NREGS_X) && !((ZERO_REG != 0) && (sel == '0));
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      case (state)
         CLEAR: begin
            busy    = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         IDLE: begin
            busy = 1'b0;
         end
         default: begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign idle          = (state == IDLE);
   assign bus.init_busy = busy;
   assign wv0 = idle && bus.we0 && sel_ok(bus.wsel0);
   assign wv1 = idle && bus.we1 && sel_ok(bus.wsel1);
   assign mv  = idle && bus.mark_en && sel_ok(bus.mark_sel);

   // Port 1 is written last so it wins a same-entry collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[cnt] <= '0;
         end else begin
            if (wv0) mem[bus.wsel0] <= bus.wdata0;
            if (wv1) mem[bus.wsel1] <= bus.wdata1;
         end
      end
   end

   // The mark is applied after the write clears so a colliding mark leaves the bit set.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= '0;
      end else begin
         if (wv0) pend[bus.wsel0]   <= 1'b0;
         if (wv1) pend[bus.wsel1]   <= 1'b0;
         if (mv)  pend[bus.mark_sel] <= 1'b1;
      end
   end

   always_comb begin
      bus.rdata0 = '0;
      bus.pend0  = 1'b0;
      if (idle && sel_ok(bus.rsel0)) begin
         bus.pend0 = pend[bus.rsel0];
         if ((BYPASS != 0) && wv1 && (bus.wsel1 == bus.rsel0)) begin
            bus.rdata0 = bus.wdata1;
            bus.pend0  = 1'b0;
         end else if ((BYPASS != 0) && wv0 && (bus.wsel0 == bus.rsel0)) begin
            bus.rdata0 = bus.wdata0;
            bus.pend0  = 1'b0;
         end else begin
            bus.rdata0 = mem[bus.rsel0];
         end
      end
   end

   always_comb begin
      bus.rdata1 = '0;
      bus.pend1  = 1'b0;
      if (idle && sel_ok(bus.rsel1)) begin
         bus.pend1 = pend[bus.rsel1];
         if ((BYPASS != 0) && wv1 && (bus.wsel1 == bus.rsel1)) begin
            bus.rdata1 = bus.wdata1;
            bus.pend1  = 1'b0;
         end else if ((BYPASS != 0) && wv0 && (bus.wsel0 == bus.rsel1)) begin
            bus.rdata1 = bus.wdata0;
            bus.pend1  = 1'b0;
         end else begin
            bus.rdata1 = mem[bus.rsel1];
         end
      end
   end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of register entries (2..256).
REQ-003 SHALL have parameter AW, default 5, select width; the integrator SHALL set 2^AW >= NREGS.
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-005 SHALL have parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to the reads.
REQ-006 SHALL have port clk  in  1  the single clock; all state changes on the rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port init_busy  out  1  high while the clear sequence runs.
REQ-009 SHALL have ports rsel0, rsel1  in  AW  read selects.
REQ-010 SHALL have ports rdata0, rdata1  out  WIDTH  read data, combinational.
REQ-011 SHALL have ports we0, we1  in  1  write enables.
REQ-012 SHALL have ports wsel0, wsel1  in  AW  write selects.
REQ-013 SHALL have ports wdata0, wdata1  in  WIDTH  write data.
REQ-014 SHALL have ports mark_en  in  1 and mark_sel  in  AW  that set an entry's pending bit.
REQ-015 SHALL have ports pend0, pend1  out  1  pending status of rsel0 and rsel1.

Function
REQ-016 SHALL implement a two-state FSM with states CLEAR and IDLE, plus a clear counter cnt of AW bits.
REQ-017 In CLEAR, each rising edge SHALL write zero to entry cnt and increment cnt; when cnt==NREGS-1, the next state SHALL be IDLE.
REQ-018 init_busy SHALL be 1 in CLEAR and 0 in IDLE; the full clear SHALL take exactly NREGS cycles after reset deasserts.
REQ-019 In CLEAR, we0, we1 and mark_en SHALL be ignored; rdata0, rdata1, pend0 and pend1 SHALL read 0.
REQ-020 In IDLE, on a rising edge with weN=1, entry wselN SHALL take wdataN, except when wselN>=NREGS or (ZERO_REG=1 and wselN=0); those writes SHALL be dropped.
REQ-021 When both ports write the same entry in the same cycle, port 1 SHALL win.
REQ-022 rdataN SHALL be 0 when rselN>=NREGS, or when ZERO_REG=1 and rselN=0.
REQ-023 With BYPASS=1, rdataN SHALL equal the wdata of a valid same-cycle write to rselN (port 1 priority); otherwise it SHALL equal the stored entry.
REQ-024 With BYPASS=0, rdataN SHALL show the stored entry, and new data SHALL appear the cycle after the write.
REQ-025 mark_en SHALL set pend[mark_sel] on the rising edge.
REQ-026 A valid write SHALL clear pend[wselN] on the rising edge.
REQ-027 When a mark and a write target the same entry in one cycle, the mark SHALL win and the bit SHALL end set.
REQ-028 mark_en to entry 0 with ZERO_REG=1, or to an entry >=NREGS, SHALL be ignored.
REQ-029 pendN SHALL equal pend[rselN]; with BYPASS=1 it SHALL be forced to 0 when a valid same-cycle write targets rselN.

Reset
REQ-030 reset=1 at a rising edge SHALL set the state to CLEAR, cnt to 0, all pend bits to 0 and init_busy to 1, from any state.
REQ-031 reset held high SHALL hold cnt at 0 with no entry advance; the clear SHALL begin on the first edge with reset=0.
REQ-032 reset asserted mid-clear SHALL restart the sequence from entry 0.
REQ-033 Entry contents SHALL be unspecified until cleared by the sequence.

Verification
REQ-034 Reset 1 cycle, NREGS=32 -> init_busy high for exactly 32 cycles; after it falls, reads of entries 1..31 return 0.
REQ-035 Write we0 to entry 5 with 0xDEADBEEF, rsel0=5 in the same cycle, BYPASS=1 -> rdata0=0xDEADBEEF in that cycle; with BYPASS=0 -> old value, then 0xDEADBEEF the next cycle.
REQ-036 Dual write to entry 7 (wdata0=0x11, wdata1=0x22) -> entry 7 reads 0x22; write to entry 0 with 0xFFFF, ZERO_REG=1 -> rdata reads 0.
REQ-037 mark entry 9 -> pend0=1 with rsel0=9; write entry 9 -> pend0=0 the next cycle; mark and write entry 9 in the same cycle -> pend0 stays 1.
REQ-038 Assert reset at clear cycle 10 -> init_busy stays high and the count restarts, giving 32 further cycles; a write attempted during CLEAR -> entry reads 0 after the clear.
